counter_reload: RTL and testbench



---
 rtl/counter_reload.sv | 105 ++++++++++
 tb/tb_counter_reload.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_reload.sv
// rtl/counter_reload.sv - loadable down-counter with periodic/one-shot terminal reload and shadowed load port
module counter_reload #(
    parameter int WIDTH          = 32,
    parameter int IMPLEMENTATION = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ena,
    input  logic             mode,
    input  logic             ld_vld,
    output logic             ld_rdy,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] cnt,
    output logic             run,
    output logic             wrp
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rld;
    logic [WIDTH-1:0] shd;
    logic             pnd;

    logic             xfer;
    logic             term;
    logic             dec_en;
    logic [WIDTH-1:0] dec_val;

    assign ld_rdy = ~pnd;
    assign xfer   = ld_vld & ~pnd;
    assign run    = (state == RUN);
    assign wrp    = run & (cnt == '0);
    assign term   = ena & wrp;

    // Both structures give the same next count; they differ only in where ena enters.
    generate
        if (IMPLEMENTATION == 0) begin : g_carry
            assign dec_val = cnt - WIDTH'(ena);
            assign dec_en  = 1'b1;
        end else if (IMPLEMENTATION == 1) begin : g_mux
            assign dec_val = cnt - WIDTH'(1);
            assign dec_en  = ena;
        end else begin : g_bad
            $fatal(1, "counter_reload: IMPLEMENTATION must be 0 or 1");
            assign dec_val = cnt;
            assign dec_en  = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            rld   <= '0;
            shd   <= '0;
            pnd   <= 1'b0;
        end else if (clr) begin
            // A load accepted in this cycle is intentionally dropped.
            state <= IDLE;
            cnt   <= '0;
            pnd   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        cnt   <= ld_val;
                        rld   <= ld_val;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (term) begin
                        // Reload priority: same-cycle load, then shadow, then current period.
                        if (xfer) begin
                            cnt <= ld_val;
                            rld <= ld_val;
                        end else if (pnd) begin
                            cnt <= shd;
                            rld <= shd;
                            pnd <= 1'b0;
                        end else if (!mode) begin
                            cnt <= rld;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        if (xfer) begin
                            shd <= ld_val;
                            pnd <= 1'b1;
                        end
                        if (dec_en) begin
                            cnt <= dec_val;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_reload.sv
// tb/tb_counter_reload.sv - checks both decrement structures against a table and a queue-based reference model
module tb_counter_reload;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst, clr, ena, mode, ld_vld;
    logic [W-1:0] ld_val;
    logic         rdy0, run0, wrp0, rdy1, run1, wrp1;
    logic [W-1:0] cnt0, cnt1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    counter_reload #(.WIDTH(W), .IMPLEMENTATION(0)) d0 (
        .clk(clk), .rst(rst), .clr(clr), .ena(ena), .mode(mode),
        .ld_vld(ld_vld), .ld_rdy(rdy0), .ld_val(ld_val),
        .cnt(cnt0), .run(run0), .wrp(wrp0)
    );

    counter_reload #(.WIDTH(W), .IMPLEMENTATION(1)) d1 (
        .clk(clk), .rst(rst), .clr(clr), .ena(ena), .mode(mode),
        .ld_vld(ld_vld), .ld_rdy(rdy1), .ld_val(ld_val),
        .cnt(cnt1), .run(run1), .wrp(wrp1)
    );

    // Reference model: a running flag, an integer count and a queue holding at most one pending period.
    bit m_run;
    int m_cnt;
    int m_rld;
    int m_pend[$];

    function automatic bit m_rdy();
        return m_pend.size() == 0;
    endfunction

    function automatic bit m_wrp();
        return m_run && m_cnt == 0;
    endfunction

    task automatic model_reset();
        m_run = 0;
        m_cnt = 0;
        m_rld = 0;
        m_pend.delete();
    endtask

    task automatic model_step(input bit c, input bit e, input bit md, input bit v, input int val);
        bit take;
        take = v && m_rdy();
        if (c) begin
            m_run = 0;
            m_cnt = 0;
            m_pend.delete();
        end else if (!m_run) begin
            if (take) begin
                m_cnt = val;
                m_rld = val;
                m_run = 1;
            end
        end else if (e && m_cnt == 0) begin
            if (take) begin
                m_rld = val;
                m_cnt = m_rld;
            end else if (m_pend.size() != 0) begin
                m_rld = m_pend.pop_front();
                m_cnt = m_rld;
            end else if (md) begin
                m_run = 0;
            end else begin
                m_cnt = m_rld;
            end
        end else begin
            if (take) m_pend.push_back(val);
            if (e) m_cnt = (m_cnt - 1) & MASK;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input int c, input bit r, input bit w, input bit y);
        chk({tag, " cnt i0"}, int'(cnt0), c);
        chk({tag, " run i0"}, int'(run0), int'(r));
        chk({tag, " wrp i0"}, int'(wrp0), int'(w));
        chk({tag, " rdy i0"}, int'(rdy0), int'(y));
        chk({tag, " cnt i1"}, int'(cnt1), c);
        chk({tag, " run i1"}, int'(run1), int'(r));
        chk({tag, " wrp i1"}, int'(wrp1), int'(w));
        chk({tag, " rdy i1"}, int'(rdy1), int'(y));
    endtask

    task automatic step(input string tag);
        model_step(clr, ena, mode, ld_vld, int'(ld_val));
        @(posedge clk);
        #1;
        check_outs({tag, " model"}, m_cnt, m_run, m_wrp(), m_rdy());
    endtask

    task automatic drive(input bit c, input bit e, input bit md, input bit v, input int val);
        clr    = c;
        ena    = e;
        mode   = md;
        ld_vld = v;
        ld_val = W'(val);
    endtask

    typedef struct {
        bit c, e, md, v;
        int val;
        int x_cnt;
        bit x_run, x_wrp, x_rdy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit c, bit e, bit md, bit v, int val, int xc, bit xr, bit xw, bit xy);
        vec_t t;
        t.c = c; t.e = e; t.md = md; t.v = v; t.val = val;
        t.x_cnt = xc; t.x_run = xr; t.x_wrp = xw; t.x_rdy = xy;
        return t;
    endfunction

    initial begin
        // periodic load 3
        vecs.push_back(mk(0,1,0,1,3, 3,1,0,1));
        vecs.push_back(mk(0,1,0,0,0, 2,1,0,1));
        vecs.push_back(mk(0,1,0,0,0, 1,1,0,1));
        vecs.push_back(mk(0,1,0,0,0, 0,1,1,1));
        vecs.push_back(mk(0,1,0,0,0, 3,1,0,1));
        vecs.push_back(mk(0,1,0,0,0, 2,1,0,1));
        vecs.push_back(mk(0,1,0,0,0, 1,1,0,1));
        vecs.push_back(mk(0,1,0,0,0, 0,1,1,1));
        // one-shot stop, then one-shot load 2
        vecs.push_back(mk(0,1,1,0,0, 0,0,0,1));
        vecs.push_back(mk(0,1,1,0,0, 0,0,0,1));
        vecs.push_back(mk(0,1,1,1,2, 2,1,0,1));
        vecs.push_back(mk(0,1,1,0,0, 1,1,0,1));
        vecs.push_back(mk(0,1,1,0,0, 0,1,1,1));
        vecs.push_back(mk(0,1,1,0,0, 0,0,0,1));
        vecs.push_back(mk(0,1,1,0,0, 0,0,0,1));
        // shadow update: run with 5, load 1 at cnt 3
        vecs.push_back(mk(0,1,0,1,5, 5,1,0,1));
        vecs.push_back(mk(0,1,0,0,0, 4,1,0,1));
        vecs.push_back(mk(0,1,0,0,0, 3,1,0,1));
        vecs.push_back(mk(0,1,0,1,1, 2,1,0,0));
        vecs.push_back(mk(0,1,0,0,0, 1,1,0,0));
        vecs.push_back(mk(0,1,0,0,0, 0,1,1,0));
        vecs.push_back(mk(0,1,0,0,0, 1,1,0,1));
        vecs.push_back(mk(0,1,0,0,0, 0,1,1,1));
        vecs.push_back(mk(0,1,0,0,0, 1,1,0,1));
        vecs.push_back(mk(0,1,0,0,0, 0,1,1,1));
        // bypass at terminal count, then back-pressure
        vecs.push_back(mk(1,1,0,0,0, 0,0,0,1));
        vecs.push_back(mk(0,1,0,1,2, 2,1,0,1));
        vecs.push_back(mk(0,1,0,0,0, 1,1,0,1));
        vecs.push_back(mk(0,1,0,0,0, 0,1,1,1));
        vecs.push_back(mk(0,1,0,1,7, 7,1,0,1));
        vecs.push_back(mk(0,1,0,1,9, 6,1,0,0));
        vecs.push_back(mk(0,1,0,1,4, 5,1,0,0));
        vecs.push_back(mk(0,1,0,1,4, 4,1,0,0));
        vecs.push_back(mk(0,1,0,1,4, 3,1,0,0));
        vecs.push_back(mk(0,1,0,1,4, 2,1,0,0));
        vecs.push_back(mk(0,1,0,1,4, 1,1,0,0));
        vecs.push_back(mk(0,1,0,1,4, 0,1,1,0));
        vecs.push_back(mk(0,1,0,1,4, 9,1,0,1));
        vecs.push_back(mk(0,1,0,1,4, 8,1,0,0));
        // clr with pending shadow, gating, clr with dropped load
        vecs.push_back(mk(1,1,0,0,0, 0,0,0,1));
        vecs.push_back(mk(0,0,0,1,4, 4,1,0,1));
        vecs.push_back(mk(0,1,0,0,0, 3,1,0,1));
        vecs.push_back(mk(0,0,0,0,0, 3,1,0,1));
        vecs.push_back(mk(0,1,0,0,0, 2,1,0,1));
        vecs.push_back(mk(1,1,0,1,5, 0,0,0,1));
        vecs.push_back(mk(0,1,0,0,0, 0,0,0,1));
    end

    initial begin
        int wraps;
        bit pv;
        int pval;

        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 0, 0, 0, 1);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].c, vecs[i].e, vecs[i].md, vecs[i].v, vecs[i].val);
            step($sformatf("vec%0d", i));
            check_outs($sformatf("vec%0d table", i), vecs[i].x_cnt, vecs[i].x_run,
                       vecs[i].x_wrp, vecs[i].x_rdy);
        end

        // load 15: one terminal event every 16 enabled cycles
        drive(1, 0, 0, 0, 0); step("p16 clr");
        drive(0, 1, 0, 1, 15); step("p16 load");
        drive(0, 1, 0, 0, 0);
        wraps = 0;
        for (int i = 0; i < 32; i++) begin
            step("p16");
            if (wrp0) wraps++;
        end
        chk("p16 wrap count", wraps, 2);

        // load 0: terminal status every running cycle
        drive(1, 0, 0, 0, 0); step("z clr");
        drive(0, 1, 0, 1, 0); step("z load");
        drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step("z");
            chk("z wrp const", int'(wrp1), 1);
        end
        drive(0, 1, 1, 0, 0); step("z oneshot");
        chk("z oneshot idle", int'(run0), 0);

        // asynchronous reset mid-count
        drive(0, 1, 0, 1, 4); step("rst load");
        drive(0, 1, 0, 1, 6); step("rst dec1");
        drive(0, 1, 0, 0, 0); step("rst dec2");
        chk("rst precond", int'(cnt0), 2);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outs("async rst", 0, 0, 0, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        check_outs("rst held", 0, 0, 0, 1);

        // randomized traffic; a stalled load keeps its value
        pv = 0;
        pval = 0;
        for (int i = 0; i < 600; i++) begin
            bit v;
            int val;
            if (pv && !m_rdy()) begin
                v = 1;
                val = pval;
            end else begin
                v = ($urandom_range(0, 3) == 0);
                val = $urandom_range(0, MASK);
            end
            drive($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, v, val);
            pv = v;
            pval = val;
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
